word32_tx16: RTL

- Transmit side of the two-half 16-bit word transfer used by the divide-by-255 datapath.
- Accepts a 32-bit word in one cycle, then drives it onto a 16-bit bus, most significant half first and least significant half second.
- Drives the two phase strobes the receiver uses: strb1 starts the transfer, strb2 switches the receiver from the MSB half to the LSB half.
- Sits between a result producer and any 16-bit receiver of this protocol, for example a loopback test of the divider.

---
 rtl/word32_tx16.sv | 132 +++++++++++++
 1 files changed

// File: rtl/word32_tx16.sv
// Transmit half of the two-phase 16-bit word transfer: sends a 32-bit word MSB half first,
// framed by strb1 (start) and strb2 (switch to LSB half), then pulses done.
module word32_tx16 #(
    parameter int HOLD_CYCLES = 2,
    parameter int LO_CYCLES   = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      data_in,
    output logic [15:0]      x_out,
    output logic             strb1,
    output logic             strb2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_count
);

    typedef enum logic [2:0] {IDLE, START, HI, LO, DONE} state_t;

    localparam logic [7:0] HI_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] LO_LAST = 8'(LO_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       hold_q, hold_d;
    logic [15:0]      x_q, x_d;
    logic             strb1_q, strb1_d;
    logic             strb2_q, strb2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Outputs are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        x_d     = '0;
        strb1_d = 1'b0;
        strb2_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    word_d  = data_in;
                    state_d = START;
                end
            end
            START: begin
                state_d = HI;
                hold_d  = '0;
            end
            HI: begin
                if (hold_q == HI_LAST) begin
                    state_d = LO;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            LO: begin
                if (hold_q == LO_LAST) begin
                    state_d = DONE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            START: begin
                x_d     = word_d[31:16];
                strb1_d = 1'b1;
                busy_d  = 1'b1;
            end
            HI: begin
                x_d     = word_d[31:16];
                strb2_d = (hold_d == HI_LAST);
                busy_d  = 1'b1;
            end
            LO: begin
                x_d    = word_d[15:0];
                busy_d = 1'b1;
            end
            DONE: begin
                x_d    = word_d[15:0];
                done_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            default: x_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            hold_q  <= '0;
            x_q     <= '0;
            strb1_q <= 1'b0;
            strb2_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            strb1_q <= strb1_d;
            strb2_q <= strb2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_out    = x_q;
    assign strb1    = strb1_q;
    assign strb2    = strb2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_count = cnt_q;

endmodule
